// File: rtl/uart_core.sv
// Full-duplex UART: 8N1 by default; defining UART_PARITY_EN adds an
// even-parity bit before the stop bit and a parity_err output pulse.
module uart_core #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       wr_rdy,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       rd_rdy,
`ifdef UART_PARITY_EN
  output logic       parity_err,
`endif
  input  logic       rx,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;

  st_t           tst_q, tst_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    tbit_q, tbit_d;
  logic [7:0]    tsh_q, tsh_d;
  logic          tx_q, tx_d;
  logic          tdone;
`ifdef UART_PARITY_EN
  logic          tpar_q, tpar_d;
`endif

  st_t           rst_q, rst_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [2:0]    rbit_q, rbit_d;
  logic [7:0]    rsh_q, rsh_d;
  logic [7:0]    dout_q, dout_d;
  logic          rdy_q, rdy_d;
  logic [1:0]    sync_q;
  logic          rxs;
  logic          rtick;
`ifdef UART_PARITY_EN
  logic          rpar_q, rpar_d;
  logic          perr_q, perr_d;
`endif

  assign tdone  = (tcnt_q == FULL);
  assign wr_rdy = (tst_q == S_IDLE);
  assign tx     = tx_q;

  always_comb begin
    tst_d  = tst_q;
    tbit_d = tbit_q;
    tsh_d  = tsh_q;
    tx_d   = 1'b1;
`ifdef UART_PARITY_EN
    tpar_d = tpar_q;
`endif
    tcnt_d = (tst_q == S_IDLE || tdone) ? '0 : tcnt_q + CW'(1);
    unique case (tst_q)
      S_IDLE: begin
        if (wr_en) begin
          tst_d = S_START;
          tsh_d = din;
`ifdef UART_PARITY_EN
          tpar_d = ^din;
`endif
        end
      end
      S_START: begin
        if (tdone) begin
          tst_d  = S_DATA;
          tbit_d = 3'd0;
        end
      end
      S_DATA: begin
        if (tdone) begin
          tsh_d  = tsh_q >> 1;
          tbit_d = tbit_q + 3'd1;
          if (tbit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            tst_d = S_PAR;
`else
            tst_d = S_STOP;
`endif
          end
        end
      end
      S_PAR: begin
        if (tdone) tst_d = S_STOP;
      end
      S_STOP: begin
        if (tdone) tst_d = S_IDLE;
      end
      default: tst_d = S_IDLE;
    endcase
    // tx is registered from next state so the pin never glitches
    case (tst_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = tsh_d[0];
`ifdef UART_PARITY_EN
      S_PAR:   tx_d = tpar_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tst_q  <= S_IDLE;
      tcnt_q <= '0;
      tbit_q <= 3'd0;
      tsh_q  <= 8'h00;
      tx_q   <= 1'b1;
`ifdef UART_PARITY_EN
      tpar_q <= 1'b0;
`endif
    end else begin
      tst_q  <= tst_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tsh_q  <= tsh_d;
      tx_q   <= tx_d;
`ifdef UART_PARITY_EN
      tpar_q <= tpar_d;
`endif
    end
  end

  assign rxs    = sync_q[1];
  assign rtick  = (rst_q == S_START) ? (rcnt_q == HALF)
                                     : (rcnt_q == FULL);
  assign dout   = dout_q;
  assign rd_rdy = rdy_q;
`ifdef UART_PARITY_EN
  assign parity_err = perr_q;
`endif

  always_comb begin
    rst_d  = rst_q;
    rbit_d = rbit_q;
    rsh_d  = rsh_q;
    dout_d = dout_q;
    rdy_d  = 1'b0;
`ifdef UART_PARITY_EN
    rpar_d = rpar_q;
    perr_d = 1'b0;
`endif
    rcnt_d = (rst_q == S_IDLE || rtick) ? '0 : rcnt_q + CW'(1);
    unique case (rst_q)
      S_IDLE: begin
        if (rd_en && !rxs) rst_d = S_START;
      end
      S_START: begin
        if (rtick) begin
          rst_d  = rxs ? S_IDLE : S_DATA;
          rbit_d = 3'd0;
        end
      end
      S_DATA: begin
        if (rtick) begin
          rsh_d  = {rxs, rsh_q[7:1]};
          rbit_d = rbit_q + 3'd1;
          if (rbit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rst_d = S_PAR;
`else
            rst_d = S_STOP;
`endif
          end
        end
      end
      S_PAR: begin
        if (rtick) begin
`ifdef UART_PARITY_EN
          rpar_d = rxs;
`endif
          rst_d = S_STOP;
        end
      end
      S_STOP: begin
        if (rtick) begin
          rst_d = S_IDLE;
          if (rxs) begin
            dout_d = rsh_q;
            rdy_d  = 1'b1;
`ifdef UART_PARITY_EN
            perr_d = (^rsh_q) ^ rpar_q;
`endif
          end
        end
      end
      default: rst_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
      rst_q  <= S_IDLE;
      rcnt_q <= '0;
      rbit_q <= 3'd0;
      rsh_q  <= 8'h00;
      dout_q <= 8'h00;
      rdy_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rpar_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      sync_q <= {sync_q[0], rx};
      rst_q  <= rst_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rsh_q  <= rsh_d;
      dout_q <= dout_d;
      rdy_q  <= rdy_d;
`ifdef UART_PARITY_EN
      rpar_q <= rpar_d;
      perr_q <= perr_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench: two uart_core instances cross-wired, with an optional
// bench-driven rx line on B for glitch and framing-error frames.
module tb_uart_core;

  localparam int CPB = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_wr_en = 1'b0, b_wr_en = 1'b0;
  logic a_rd_en = 1'b0, b_rd_en = 1'b0;
  logic [7:0] a_din = 8'h00, b_din = 8'h00;
  logic a_wr_rdy, b_wr_rdy, a_rd_rdy, b_rd_rdy;
  logic [7:0] a_dout, b_dout;
  logic a_tx, b_tx, b_rx;
  logic sel = 1'b0;
  logic tb_rx = 1'b1;
`ifdef UART_PARITY_EN
  logic a_perr, b_perr;
`endif

  int total = 0;
  int bad = 0;
  int a_cnt = 0;
  int b_cnt = 0;

  assign b_rx = sel ? tb_rx : a_tx;

  always #5 clk = ~clk;

  uart_core #(.CLKS_PER_BIT(CPB)) u_a (
    .clk(clk), .rst(rst),
    .wr_en(a_wr_en), .din(a_din), .wr_rdy(a_wr_rdy),
    .rd_en(a_rd_en), .dout(a_dout), .rd_rdy(a_rd_rdy),
`ifdef UART_PARITY_EN
    .parity_err(a_perr),
`endif
    .rx(b_tx), .tx(a_tx)
  );

  uart_core #(.CLKS_PER_BIT(CPB)) u_b (
    .clk(clk), .rst(rst),
    .wr_en(b_wr_en), .din(b_din), .wr_rdy(b_wr_rdy),
    .rd_en(b_rd_en), .dout(b_dout), .rd_rdy(b_rd_rdy),
`ifdef UART_PARITY_EN
    .parity_err(b_perr),
`endif
    .rx(b_rx), .tx(b_tx)
  );

  always @(negedge clk) begin
    if (a_rd_rdy) a_cnt++;
    if (b_rd_rdy) b_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef UART_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  task automatic send_a(input logic [7:0] d);
    a_din = d;
    a_wr_en = 1'b1;
    @(negedge clk);
    a_wr_en = 1'b0;
  endtask

  task automatic wait_b(input int n, input string tag);
    int i;
    i = 0;
    while (b_cnt < n && i < 20 * CPB) begin
      @(negedge clk);
      i++;
    end
    chk(tag, b_cnt, n);
  endtask

  task automatic send_raw(input logic [7:0] d, input logic stopb);
    tb_rx = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      tb_rx = d[i];
      cyc(CPB);
    end
`ifdef UART_PARITY_EN
    tb_rx = ^d;
    cyc(CPB);
`endif
    tb_rx = stopb;
    cyc(CPB);
    tb_rx = 1'b1;
    cyc(2 * CPB);
  endtask

  initial begin
    logic [10:0] fr;
    int n;

    cyc(3);
    chk("init_tx", a_tx, 1);
    chk("init_wr_rdy", a_wr_rdy, 1);
    chk("init_rd_rdy", b_rd_rdy, 0);
    chk("init_dout", b_dout, 8'h00);
    rst = 1'b0;
    cyc(4);

    // single byte with tx waveform check at each bit centre
    b_rd_en = 1'b1;
    b_cnt = 0;
    fr = frame(8'hE8);
    send_a(8'hE8);
    chk("accept_wr_rdy", a_wr_rdy, 0);
    cyc(CPB / 2);
    for (int j = 0; j < NB; j++) begin
      chk($sformatf("tx_bit%0d", j), a_tx, fr[j]);
      cyc(CPB);
    end
    wait_b(1, "single_pulse");
    cyc(CPB);
    chk("single_cnt", b_cnt, 1);
    chk("single_dout", b_dout, 8'hE8);

    // full duplex
    chk("fd_a_wr_rdy", a_wr_rdy, 1);
    chk("fd_b_wr_rdy", b_wr_rdy, 1);
    chk("fd_a_rd_rdy", a_rd_rdy, 0);
    chk("fd_b_rd_rdy", b_rd_rdy, 0);
    a_rd_en = 1'b1;
    b_rd_en = 1'b1;
    a_cnt = 0;
    b_cnt = 0;
    a_din = 8'hCA;
    b_din = 8'h4B;
    a_wr_en = 1'b1;
    b_wr_en = 1'b1;
    @(negedge clk);
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
    n = 0;
    while ((a_cnt < 1 || b_cnt < 1) && n < 20 * CPB) begin
      @(negedge clk);
      if (a_cnt > 0) a_rd_en = 1'b0;
      if (b_cnt > 0) b_rd_en = 1'b0;
      n++;
    end
    a_rd_en = 1'b0;
    b_rd_en = 1'b0;
    chk("fd_a_cnt", a_cnt, 1);
    chk("fd_b_cnt", b_cnt, 1);
    chk("fd_a_dout", a_dout, 8'h4B);
    chk("fd_b_dout", b_dout, 8'hCA);
    cyc(3 * CPB);
    chk("fd_a_hold", a_dout, 8'h4B);
    chk("fd_b_hold", b_dout, 8'hCA);
    chk("fd_a_cnt2", a_cnt, 1);

    // rd_en low for a whole frame
    b_cnt = 0;
    send_a(8'h55);
    cyc(12 * CPB);
    chk("rden0_cnt", b_cnt, 0);
    chk("rden0_dout", b_dout, 8'hCA);
    b_rd_en = 1'b1;
    send_a(8'hA5);
    wait_b(1, "rden1_pulse");
    cyc(CPB);
    chk("rden1_dout", b_dout, 8'hA5);

    // glitch and framing error on a bench-driven line
    sel = 1'b1;
    tb_rx = 1'b1;
    cyc(CPB);
    b_cnt = 0;
    tb_rx = 1'b0;
    cyc(2);
    tb_rx = 1'b1;
    cyc(12 * CPB);
    chk("glitch_cnt", b_cnt, 0);
    chk("glitch_dout", b_dout, 8'hA5);
    send_raw(8'h3C, 1'b0);
    chk("frame_err_cnt", b_cnt, 0);
    chk("frame_err_dout", b_dout, 8'hA5);
    send_raw(8'h3C, 1'b1);
    chk("raw_good_cnt", b_cnt, 1);
    chk("raw_good_dout", b_dout, 8'h3C);
    sel = 1'b0;
    cyc(2 * CPB);

    // back-to-back frames with wr_en held high
    b_cnt = 0;
    a_din = 8'h00;
    a_wr_en = 1'b1;
    @(negedge clk);
    a_din = 8'hFF;
    chk("b2b_acc1", a_wr_rdy, 0);
    n = 0;
    while (!a_wr_rdy && n < 12 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_low1", n, NB * CPB);
    @(negedge clk);
    a_wr_en = 1'b0;
    chk("b2b_acc2", a_wr_rdy, 0);
    n = 0;
    while (!a_wr_rdy && n < 12 * CPB) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_low2", n, NB * CPB);
    wait_b(2, "b2b_pulses");
    cyc(CPB);
    chk("b2b_dout", b_dout, 8'hFF);

    // asynchronous reset in the middle of a frame
    b_cnt = 0;
    send_a(8'h00);
    cyc(5 * CPB);
    chk("pre_rst_tx", a_tx, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", a_tx, 1);
    chk("rst_wr_rdy", a_wr_rdy, 1);
    chk("rst_rd_rdy", b_rd_rdy, 0);
    chk("rst_dout", b_dout, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    cyc(12 * CPB);
    chk("rst_no_pulse", b_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
